// File: rtl/adc_seq_ctrl.sv
// Modulator clock sequencer and sample capture for six sigma-delta channels.
// Generates mclk_out from mclkin, discards SETTLE_N edges after start, then
// strobes masked modulator bits on every mclk rising edge and flags channels
// whose bitstream stays constant for STUCK_N consecutive samples.
//
// Ports:
//   mclkin      system clock (only clock)
//   rst         synchronous active-high reset
//   enable      level request to run the modulators
//   div         mclk half-period in mclkin cycles (0 treated as 1), latched at start
//   ch_en       channel mask {u3,i3,u2,i2,u1,i1}
//   mdat_in     registered modulator bitstreams, same order
//   mclk_out    modulator clock
//   sample_stb  one-cycle strobe, mdat_out valid
//   mdat_out    captured bits masked by ch_en, held between strobes
//   ready       high while running
//   state_o     IDLE=0, START=1, RUN=2, STOP=3
//   stuck_err   sticky per-channel stuck-bitstream flags
module adc_seq_ctrl #(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned SETTLE_N = 16,
   parameter int unsigned STUCK_N  = 64
) (
   input  logic             mclkin,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic [5:0]       ch_en,
   input  logic [5:0]       mdat_in,
   output logic             mclk_out,
   output logic             sample_stb,
   output logic [5:0]       mdat_out,
   output logic             ready,
   output logic [1:0]       state_o,
   output logic [5:0]       stuck_err
);

   localparam int unsigned NCH   = 6;
   localparam int unsigned SET_W = $clog2(SETTLE_N + 1);
   localparam int unsigned REP_W = $clog2(STUCK_N + 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_N - 1);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(STUCK_N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   h_q, h_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic               mclk_q, mclk_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               stb_q, stb_d;
   logic               ready_q;
   logic [5:0]         mdat_q, mdat_d;
   logic [5:0]         err_q, err_d;
   logic [5:0]         prev_q, prev_d;
   logic [5:0]         seen_q, seen_d;
   logic [REP_W-1:0]   rep_q [NCH];
   logic [REP_W-1:0]   rep_d [NCH];
   logic               wrap;
   logic               rise;

   // State and datapath registers
   always_ff @(posedge mclkin) begin
      if (rst) begin
         state_q  <= IDLE;
         h_q      <= DIV_W'(1);
         cnt_q    <= '0;
         mclk_q   <= 1'b0;
         settle_q <= '0;
         stb_q    <= 1'b0;
         ready_q  <= 1'b0;
         mdat_q   <= '0;
         err_q    <= '0;
         prev_q   <= '0;
         seen_q   <= '0;
         for (int unsigned i = 0; i < NCH; i++) rep_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         cnt_q    <= cnt_d;
         mclk_q   <= mclk_d;
         settle_q <= settle_d;
         stb_q    <= stb_d;
         ready_q  <= (state_d == RUN);
         mdat_q   <= mdat_d;
         err_q    <= err_d;
         prev_q   <= prev_d;
         seen_q   <= seen_d;
         for (int unsigned i = 0; i < NCH; i++) rep_q[i] <= rep_d[i];
      end
   end

   // Next-state, clock divider, capture and stuck detection
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      cnt_d    = cnt_q;
      mclk_d   = mclk_q;
      settle_d = settle_q;
      stb_d    = 1'b0;
      mdat_d   = mdat_q;
      err_d    = err_q;
      prev_d   = prev_q;
      seen_d   = seen_q;
      for (int unsigned i = 0; i < NCH; i++) rep_d[i] = rep_q[i];

      wrap = (cnt_q == h_q - DIV_W'(1));
      rise = wrap && !mclk_q;

      // Divider free-runs in every active state; individual states override
      if (state_q != IDLE) begin
         cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
         if (wrap) mclk_d = !mclk_q;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            mclk_d = 1'b0;
            if (enable) begin
               state_d  = START;
               h_d      = (div == '0) ? DIV_W'(1) : div;
               settle_d = '0;
               err_d    = '0;
               seen_d   = '0;
               for (int unsigned i = 0; i < NCH; i++) rep_d[i] = '0;
            end
         end
         START: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               mclk_d  = 1'b0;
            end else if (rise) begin
               if (settle_q == SET_LAST) state_d = RUN;
               else                      settle_d = settle_q + SET_W'(1);
            end
         end
         RUN: begin
            if (rise) begin
               stb_d  = 1'b1;
               mdat_d = mdat_in & ch_en;
               // rep counts repeats after the first sample, so STUCK_N equal
               // samples correspond to rep reaching STUCK_N-1
               for (int unsigned i = 0; i < NCH; i++) begin
                  if (!ch_en[i]) begin
                     rep_d[i]  = '0;
                     seen_d[i] = 1'b0;
                  end else begin
                     if (seen_q[i] && (mdat_in[i] == prev_q[i])) begin
                        if (rep_q[i] != REP_MAX) rep_d[i] = rep_q[i] + REP_W'(1);
                        if (rep_d[i] == REP_MAX) err_d[i] = 1'b1;
                     end else begin
                        rep_d[i] = '0;
                     end
                     seen_d[i] = 1'b1;
                     prev_d[i] = mdat_in[i];
                  end
               end
            end
            if (!enable) state_d = STOP;
         end
         STOP: begin
            // Leave only with mclk low so the high phase is never cut short
            if (!mclk_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               mclk_d  = 1'b0;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mclk_out   = mclk_q;
   assign sample_stb = stb_q;
   assign mdat_out   = mdat_q;
   assign ready      = ready_q;
   assign state_o    = state_q;
   assign stuck_err  = err_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: a phase-time model (mclk derived from cycles since
// start) is stepped every clock and compared to the DUT each cycle, alongside
// directed scenarios with hand-computed expectations.
module tb_adc_seq_ctrl;

   localparam int unsigned DIV_W    = 8;
   localparam int unsigned SETTLE_N = 16;
   localparam int unsigned STUCK_N  = 64;

   logic             mclkin  = 1'b0;
   logic             rst     = 1'b1;
   logic             enable  = 1'b0;
   logic [DIV_W-1:0] div     = '0;
   logic [5:0]       ch_en   = '0;
   logic [5:0]       mdat_in = '0;
   logic             mclk_out;
   logic             sample_stb;
   logic [5:0]       mdat_out;
   logic             ready;
   logic [1:0]       state_o;
   logic [5:0]       stuck_err;

   int tests = 0;
   int fails = 0;

   adc_seq_ctrl #(
      .DIV_W   (DIV_W),
      .SETTLE_N(SETTLE_N),
      .STUCK_N (STUCK_N)
   ) dut (
      .mclkin    (mclkin),
      .rst       (rst),
      .enable    (enable),
      .div       (div),
      .ch_en     (ch_en),
      .mdat_in   (mdat_in),
      .mclk_out  (mclk_out),
      .sample_stb(sample_stb),
      .mdat_out  (mdat_out),
      .ready     (ready),
      .state_o   (state_o),
      .stuck_err (stuck_err)
   );

   always #5 mclkin = ~mclkin;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   // Model: t = cycles since entering START; mclk is high while (t/H) is odd,
   // rising edges at t = H, 3H, 5H, ...; run length of identical samples per channel.
   int         m_state = 0;
   int         m_t     = 0;
   int         m_h     = 1;
   logic       m_mclk  = 1'b0;
   logic       m_stb   = 1'b0;
   logic [5:0] m_mdat  = '0;
   logic [5:0] m_err   = '0;
   logic [5:0] m_prev  = '0;
   int         m_run [6];
   bit         m_valid = 1'b0;

   task automatic model_step();
      bit rose;
      if (rst) begin
         m_state = 0; m_t = 0; m_h = 1; m_mclk = 1'b0; m_stb = 1'b0;
         m_mdat = '0; m_err = '0; m_prev = '0; m_valid = 1'b1;
         for (int i = 0; i < 6; i++) m_run[i] = 0;
         return;
      end
      m_stb = 1'b0;
      case (m_state)
         0: begin
            if (enable) begin
               m_state = 1; m_t = 0;
               m_h = (div == '0) ? 1 : int'(div);
               m_err = '0;
               for (int i = 0; i < 6; i++) m_run[i] = 0;
            end
         end
         1: begin
            if (!enable) begin
               m_state = 0; m_mclk = 1'b0;
            end else begin
               m_t++;
               m_mclk = ((m_t / m_h) % 2) == 1;
               rose = (m_t % (2 * m_h)) == m_h;
               if (rose && ((m_t - m_h) / (2 * m_h) + 1) == int'(SETTLE_N)) m_state = 2;
            end
         end
         2: begin
            m_t++;
            m_mclk = ((m_t / m_h) % 2) == 1;
            if ((m_t % (2 * m_h)) == m_h) begin
               m_stb  = 1'b1;
               m_mdat = mdat_in & ch_en;
               for (int i = 0; i < 6; i++) begin
                  if (!ch_en[i]) m_run[i] = 0;
                  else if (m_run[i] > 0 && mdat_in[i] == m_prev[i]) m_run[i]++;
                  else m_run[i] = 1;
                  m_prev[i] = mdat_in[i];
                  if (m_run[i] >= int'(STUCK_N)) m_err[i] = 1'b1;
               end
            end
            if (!enable) m_state = 3;
         end
         default: begin
            if (!m_mclk) m_state = 0;
            else begin
               m_t++;
               m_mclk = ((m_t / m_h) % 2) == 1;
               if (!m_mclk) m_state = 0;
            end
         end
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: step the model at the edge, compare everything on the falling edge
   task automatic tick();
      logic [1:0] ms;
      logic       mr;
      @(posedge mclkin);
      model_step();
      @(negedge mclkin);
      if (m_valid) begin
         ms = 2'(m_state);
         mr = (m_state == 2);
         check("model", 32'({state_o, mclk_out, sample_stb, ready, mdat_out, stuck_err}),
               32'({ms, m_mclk, m_stb, mr, m_mdat, m_err}));
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return ready;
         1:       return sample_stb;
         2:       return mclk_out;
         default: return state_o == 2'd0;
      endcase
   endfunction

   // Bounded wait for a DUT condition; k returns the cycles waited
   task automatic wait_sig(input string name, input int which, input int budget, output int k);
      k = 0;
      while (sig(which) == 1'b0 && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(sig(which)), 32'd1);
   endtask

   initial begin
      int   k;
      logic prev;

      // Reset
      tick(); tick();
      check("reset_outputs", 32'({state_o, mclk_out, sample_stb, ready, mdat_out, stuck_err}), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_hold", 32'(state_o), 32'd0);

      // Start-up, div=2: period 4, ready after 16th edge, first strobe at 17th
      div = 8'd2; ch_en = 6'h3f; mdat_in = 6'h15; enable = 1'b1;
      tick();
      check("start_entry", 32'(state_o), 32'd1);
      wait_sig("ready_rise", 0, 200, k);
      check("ready_latency_div2", 32'(k), 32'd62);
      wait_sig("first_stb", 1, 20, k);
      check("first_stb_latency", 32'(k), 32'd4);
      tick(); check("duty_hi", 32'(mclk_out), 32'd1);
      tick(); check("duty_lo1", 32'(mclk_out), 32'd0);
      ch_en = 6'b101010; mdat_in = 6'b111111;
      tick(); check("duty_lo2", 32'(mclk_out), 32'd0);
      tick(); check("period_rise", 32'({mclk_out, sample_stb}), 32'd3);
      check("capture", 32'(mdat_out), 32'h2a);
      mdat_in = 6'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("capture_hold", 32'({sample_stb, mdat_out}), 32'h2a);
      end
      tick();
      check("capture_next", 32'({sample_stb, mdat_out}), 32'h40);
      enable = 1'b0;
      wait_sig("stop_idle1", 3, 20, k);

      // div=0 behaves as 1; div change during RUN ignored
      div = 8'd0; ch_en = 6'h3f; enable = 1'b1;
      tick();
      check("start_div0", 32'(state_o), 32'd1);
      wait_sig("ready_div0", 0, 200, k);
      check("ready_latency_div0", 32'(k), 32'd31);
      prev = mclk_out;
      for (int i = 0; i < 6; i++) begin
         tick(); check("toggle_div0", 32'(mclk_out), 32'(!prev)); prev = mclk_out;
      end
      div = 8'd5;
      for (int i = 0; i < 6; i++) begin
         tick(); check("toggle_after_div", 32'(mclk_out), 32'(!prev)); prev = mclk_out;
      end
      enable = 1'b0;
      wait_sig("stop_idle2", 3, 20, k);

      // Stop with div=3, enable dropped one cycle after a rising edge
      div = 8'd3; enable = 1'b1;
      tick();
      wait_sig("ready_div3", 0, 300, k);
      wait_sig("stb_div3", 1, 20, k);
      enable = 1'b0;
      tick(); check("stop_hi1", 32'({state_o, mclk_out}), 32'b111);
      tick(); check("stop_hi2", 32'({state_o, mclk_out}), 32'b111);
      tick(); check("stop_fall", 32'({state_o, mclk_out}), 32'b000);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sample_stb) k++;
      end
      check("no_stb_after_stop", 32'(k), 32'd0);

      // Stuck detection: i1 held 1, u1 toggled each sample
      div = 8'd0; ch_en = 6'h3f; mdat_in = 6'b000001; enable = 1'b1;
      tick();
      wait_sig("ready_stuck", 0, 200, k);
      for (int s = 1; s <= 64; s++) begin
         wait_sig("stb_stuck", 1, 10, k);
         if (s == 63) check("stuck_before", 32'(stuck_err[0]), 32'd0);
         if (s == 64) check("stuck_set", 32'({stuck_err[1], stuck_err[0]}), 32'b01);
         mdat_in[1] = !mdat_in[1];
         tick();
      end
      enable = 1'b0;
      wait_sig("stop_idle4", 3, 20, k);
      check("stuck_sticky", 32'(stuck_err), 32'b111101);
      enable = 1'b1;
      tick();
      check("stuck_clear", 32'({state_o, stuck_err}), 32'({2'd1, 6'd0}));

      // Reset in RUN while mclk is high, enable held
      wait_sig("ready_rst", 0, 200, k);
      wait_sig("mclk_hi", 2, 10, k);
      check("run_before_rst", 32'(state_o), 32'd2);
      rst = 1'b1;
      tick();
      check("rst_in_run", 32'({state_o, mclk_out, sample_stb, ready, mdat_out, stuck_err}), 32'd0);
      rst = 1'b0;
      tick();
      check("restart_after_rst", 32'(state_o), 32'd1);

      enable = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
